// File: rtl/pipeir_skid.sv
// rtl/pipeir_skid.sv - IF/ID pipeline register with valid/ready handshake, one-entry skid and flush.
// Optional stall/flush perf counters are enabled by defining PIPEIR_SKID_PERF_EN.
module pipeir_skid #(
  parameter int PCW = 32,
  parameter int IW  = 32,
  parameter logic [IW-1:0] NOP_INST = '0
`ifdef PIPEIR_SKID_PERF_EN
  , parameter int CW = 16
`endif
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PCW-1:0] in_pc4,
  input  logic [IW-1:0]  in_inst,
  input  logic           flush,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [PCW-1:0] out_pc4,
  output logic [IW-1:0]  out_inst
`ifdef PIPEIR_SKID_PERF_EN
  , output logic [CW-1:0] stall_cnt,
  output logic [CW-1:0]  flush_cnt
`endif
);

  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FULL = 2'd1, S_SKID = 2'd2} state_t;

  state_t         r_state;
  state_t         w_next;
  logic [PCW-1:0] r_main_pc4;
  logic [IW-1:0]  r_main_inst;
  logic [PCW-1:0] r_skid_pc4;
  logic [IW-1:0]  r_skid_inst;
  logic           w_accept;
  logic           w_xfer;

  assign w_accept = in_valid & in_ready;
  assign w_xfer   = out_valid & out_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= S_EMPTY;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = S_EMPTY;
    end else begin
      case (r_state)
        S_EMPTY: if (w_accept) w_next = S_FULL;
        S_FULL: begin
          if (w_xfer && !w_accept)      w_next = S_EMPTY;
          else if (!w_xfer && w_accept) w_next = S_SKID;
        end
        S_SKID:  if (w_xfer) w_next = S_FULL;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // Outputs are gated by state, so stale main data never leaks while empty.
  always_comb begin
    in_ready  = (r_state != S_SKID);
    out_valid = (r_state != S_EMPTY);
    out_pc4   = (r_state != S_EMPTY) ? r_main_pc4 : '0;
    out_inst  = (r_state != S_EMPTY) ? r_main_inst : NOP_INST;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_main_pc4  <= '0;
      r_main_inst <= NOP_INST;
      r_skid_pc4  <= '0;
      r_skid_inst <= NOP_INST;
    end else if (!flush) begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_main_pc4  <= in_pc4;
            r_main_inst <= in_inst;
          end
        end
        S_FULL: begin
          if (w_accept && w_xfer) begin
            r_main_pc4  <= in_pc4;
            r_main_inst <= in_inst;
          end else if (w_accept) begin
            r_skid_pc4  <= in_pc4;
            r_skid_inst <= in_inst;
          end
        end
        S_SKID: begin
          if (w_xfer) begin
            r_main_pc4  <= r_skid_pc4;
            r_main_inst <= r_skid_inst;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPEIR_SKID_PERF_EN
  logic [CW-1:0] r_stall_cnt;
  logic [CW-1:0] r_flush_cnt;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CW'(1);
      if (flush && (r_state != S_EMPTY) && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CW'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeir_skid.sv
// tb/tb_pipeir_skid.sv - self-checking bench for pipeir_skid against a queue model.
module tb_pipeir_skid;
  localparam logic [31:0] NOP = 32'h00000000;
  localparam int          CMAX = 15;

  logic        clk, clr, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_pc4, in_inst, out_pc4, out_inst;
`ifdef PIPEIR_SKID_PERF_EN
  logic [3:0]  stall_cnt, flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  pipeir_skid #(
    .PCW(32), .IW(32), .NOP_INST(NOP)
`ifdef PIPEIR_SKID_PERF_EN
    , .CW(4)
`endif
  ) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_inst(in_inst), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc4(out_pc4), .out_inst(out_inst)
`ifdef PIPEIR_SKID_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];
  int   m_stall = 0;
  int   m_flush = 0;
  logic m_rdy, m_vld;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an in-order queue of at most two held words; head drives the outputs.
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      m_rdy = (q.size() < 2);
      m_vld = (q.size() > 0);
      if (m_vld && !out_ready && m_stall < CMAX) m_stall++;
      if (flush && m_vld && m_flush < CMAX) m_flush++;
      if (flush) begin
        q.delete();
      end else begin
        if (m_vld && out_ready) void'(q.pop_front());
        if (in_valid && m_rdy) q.push_back('{in_pc4, in_inst});
      end
    end
  end

  always @(negedge clk) begin
    check("cmp_out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    check("cmp_in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    check("cmp_out_inst", out_inst, (q.size() > 0) ? q[0].inst : NOP);
    check("cmp_out_pc4", out_pc4, (q.size() > 0) ? q[0].pc4 : 32'd0);
`ifdef PIPEIR_SKID_PERF_EN
    check("cmp_stall_cnt", {28'd0, stall_cnt}, m_stall);
    check("cmp_flush_cnt", {28'd0, flush_cnt}, m_flush);
`endif
  end

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_pc4    = pc;
    in_inst   = ins;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] pat_v, pat_o, pat_f;

  initial begin
    clr = 1'b1;
    drive(0, 0, 0, 0, 0);
    #3;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_inst", out_inst, NOP);
    check("rst_out_pc4", out_pc4, 32'd0);
    tick();
    clr = 1'b0;

    // streaming
    for (int i = 1; i <= 4; i++) begin
      drive(1, 32'h100 + 4 * i, 32'h20080000 + i, 1, 0);
      tick();
      check("stream_inst", out_inst, 32'h20080000 + i);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    drive(0, 0, 0, 1, 0);
    tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_inst", out_inst, NOP);
    tick();
    check("idle_inst", out_inst, NOP);
    check("idle_pc4", out_pc4, 32'd0);

    // backpressure into skid
    drive(1, 32'h204, 32'h11111111, 1, 0);
    tick();
    drive(1, 32'h208, 32'h22222222, 0, 0);
    tick();
    check("skid_in_ready", {31'd0, in_ready}, 32'd0);
    check("skid_head_a", out_inst, 32'h11111111);
    drive(0, 0, 0, 1, 0);
    tick();
    check("skid_then_b", out_inst, 32'h22222222);
    check("skid_pc_b", out_pc4, 32'h208);
    check("skid_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    check("skid_drained", {31'd0, out_valid}, 32'd0);

    // flush in SKID state
    drive(1, 32'h304, 32'h11111111, 0, 0);
    tick();
    drive(1, 32'h308, 32'h22222222, 0, 0);
    tick();
    drive(1, 32'h30c, 32'h33333333, 0, 1);
    tick();
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_inst", out_inst, NOP);
    check("flush_ready", {31'd0, in_ready}, 32'd1);
    drive(0, 0, 0, 1, 0);
    tick();
    check("flush_no_c", out_inst, NOP);
    drive(1, 32'h404, 32'h44444444, 1, 0);
    tick();
    check("post_flush_accept", out_inst, 32'h44444444);

    // mixed handshake patterns
    pat_v = 16'b1011_1110_0111_1011;
    pat_o = 16'b0110_0101_1100_0010;
    pat_f = 16'b0000_1000_0000_0100;
    for (int i = 0; i < 16; i++) begin
      drive(pat_v[i], 32'h1000 + 4 * i, 32'hA0000000 + i, pat_o[i], pat_f[i]);
      tick();
    end

    // async reset mid-stream
    drive(1, 32'h504, 32'h55555555, 1, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    #1;
    clr = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_pc4", out_pc4, 32'd0);
    check("arst_inst", out_inst, NOP);
    #1;
    clr = 1'b0;
    tick();

`ifdef PIPEIR_SKID_PERF_EN
    drive(1, 32'h604, 32'h66666666, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    repeat (20) tick();
    check("perf_stall_sat", {28'd0, stall_cnt}, 32'd15);
    drive(0, 0, 0, 0, 1);
    tick();
    check("perf_flush_one", {28'd0, flush_cnt}, 32'd1);
    drive(0, 0, 0, 0, 0);
    tick();
`endif

    drive(0, 0, 0, 1, 0);
    repeat (3) tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
